if_de_skid: RTL and testbench
=============================

# if_de_skid

Parametrised IF/DE pipeline stage that replaces the plain enable/stall/refresh register with a valid/ready handshake and a 2-entry skid buffer. Fetch can keep issuing for one cycle after decode stalls without losing an instruction, and `s_ready_o` is driven purely from a register. Flush drops both entries. Depending on `BUBBLE_VALID`, flush then either leaves the stage empty or injects one valid NOP bubble. It sits between the fetch unit (upstream, `s_*`) and the decoder (downstream, `m_*`).

## Interface
Parameters:
- `PC_W`, default 32: width of the PC-plus-offset field.
- `INST_W`, default 32: instruction width.
- `NOP_INST`, default `32'h00000013`: bubble instruction (`addi x0,x0,0`).
- `BUBBLE_VALID`, default 0:
  - 0: flush leaves the stage empty.
  - 1: flush presents one valid NOP.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `flush_i`, in, 1: discard all contents. Highest priority.
- `s_valid_i`, in, 1: fetch presents an instruction.
- `s_ready_o`, out, 1: stage can accept. Registered.
- `s_pc_i`, in, `PC_W`: fetch PC-adder value.
- `s_inst_i`, in, `INST_W`: fetched instruction.
- `m_valid_o`, out, 1: decode-side payload valid.
- `m_ready_i`, in, 1: decoder accepts.
- `m_pc_o`, out, `PC_W`: head PC.
- `m_inst_o`, out, `INST_W`: head instruction.
- `occ_o`, out, 2: entries held (0..2).

## Operation
- Storage: main register (drives `m_*`) plus one skid register.
- Handshakes:
  - Upstream transfer when `s_valid_i & s_ready_o`.
  - Downstream transfer when `m_valid_o & m_ready_i`.
- States, with `occ_o` equal to the entry count:
  - EMPTY (0): `m_valid_o` = 0, `s_ready_o` = 1.
  - ONE (1): `m_valid_o` = 1, `s_ready_o` = 1.
  - TWO (2): `m_valid_o` = 1, `s_ready_o` = 0.
- Transitions when `flush_i` = 0:
  - EMPTY + upstream transfer → ONE, main ← input.
  - ONE, downstream and upstream transfer → ONE, main ← input.
  - ONE, downstream transfer only → EMPTY.
  - ONE, upstream transfer only → TWO, skid ← input.
  - TWO + `m_ready_i` → ONE, main ← skid. Input ignored because `s_ready_o` = 0.
  - No event → hold state and payload.
- Flush (`flush_i` = 1, any state, overrides `m_ready_i` and `s_valid_i`):
  - Both entries are discarded, and the same-cycle input is dropped even if `s_ready_o` was 1.
  - Next state is EMPTY when `BUBBLE_VALID` = 0, ONE when `BUBBLE_VALID` = 1.
  - Main payload becomes `m_pc_o` = 0, `m_inst_o` = `NOP_INST`.
  - Skid payload is don't-care.
  - `s_ready_o` = 1 in the cycle after flush.
- Invalid payload:
  - When `m_valid_o` = 0, `m_pc_o`/`m_inst_o` hold their last value and are don't-care.
  - The payload updates only on load, skid move, flush, or reset.
- Payload is never modified in flight: PC and instruction widths pass through unchanged.
- Ordering: instructions leave in exact acceptance order. No duplication, no loss except by flush.

## Timing
- Reset (async assert, sync-deasserted by the top level):
  - State EMPTY, `occ_o` = 0.
  - `m_valid_o` = 0, `s_ready_o` = 1.
  - `m_pc_o` = 0, `m_inst_o` = 0.
  - Skid cleared.
- Reset mid-operation discards all entries immediately; no bubble is injected.
- Latency: 1 cycle from upstream transfer to `m_valid_o` when EMPTY.
- Throughput: 1 instruction per cycle sustained while `m_ready_i` = 1.
- `s_ready_o` is a flop output and equals `occ_o` != 2. There is no combinational path from `m_ready_i` to `s_ready_o`.
- `m_*` outputs are flop outputs.
- Flush takes effect at the next edge. The output reflects EMPTY or the bubble 1 cycle after `flush_i` is sampled.
- Bubble (`BUBBLE_VALID` = 1): the NOP stays valid until the decoder accepts it, exactly like a normal entry.
- Flush held high for N cycles:
  - Stage stays EMPTY, or re-injects the NOP each cycle without accumulating (`occ_o` ≤ 1).
  - Input is dropped every flush cycle.

## Test plan
- **Reset and streaming.** Stimulus: reset, then `s_valid_i` = 1 for 4 cycles with inst 0x11..0x14, `m_ready_i` = 1. Required response:
  - During reset, all outputs are at their reset values.
  - `m_inst_o` shows 0x11..0x14 on consecutive cycles starting 1 cycle after the first transfer.
  - `occ_o` stays at 1.
- **Skid fill.** Stimulus: stream 0x21, 0x22, 0x23 with `m_ready_i` = 0 from cycle 1. Required response:
  - `occ_o` = 2 and `s_ready_o` = 0.
  - 0x23 is held by fetch.
  - Releasing `m_ready_i` yields 0x21, 0x22, 0x23 in order with no gaps.
- **Simultaneous in/out in ONE.** Stimulus: `m_ready_i` = 1 and `s_valid_i` = 1 together in ONE. Required response: `occ_o` stays 1 and main is replaced with the new instruction.
- **Flush in TWO, `BUBBLE_VALID` = 0.** Stimulus: flush with 0x31/0x32 held and `s_valid_i` = 1. Required response:
  - Next cycle `occ_o` = 0, `m_valid_o` = 0, `s_ready_o` = 1.
  - Neither 0x31, 0x32, nor the input ever appears downstream.
- **Flush, `BUBBLE_VALID` = 1.** Stimulus: flush, then `m_ready_i` low for 2 cycles. Required response:
  - `m_valid_o` = 1, `m_inst_o` = 0x00000013, `m_pc_o` = 0, held for 2 cycles.
  - The NOP is consumed once.
  - A 3-cycle flush leaves `occ_o` = 1.
- **Async reset mid-stream.** Stimulus: assert `rst_n` low between edges with `occ_o` = 2. Required response: outputs go to reset values immediately, with no clock edge needed.

Source files
------------

// File: rtl/if_de_skid.sv
// IF/DE pipeline stage: valid/ready handshake with a 2-entry skid buffer.
// The main register drives the decode side (m_*). The skid register catches
// the one instruction that fetch may still issue after decode stalls.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_EMPTY | no entries; m_valid_o = 0, s_ready_o = 1
// ST_ONE   | main holds the head; m_valid_o = 1, s_ready_o = 1
// ST_TWO   | main holds the head, skid holds the next; s_ready_o = 0
//
// The state encoding equals the entry count, so occ_o is the state register.
module if_de_skid #(
  parameter int unsigned             PC_W         = 32,
  parameter int unsigned             INST_W       = 32,
  parameter logic [INST_W-1:0]       NOP_INST     = INST_W'(32'h00000013),
  parameter bit                      BUBBLE_VALID = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [PC_W-1:0]   s_pc_i,
  input  logic [INST_W-1:0] s_inst_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [PC_W-1:0]   m_pc_o,
  output logic [INST_W-1:0] m_inst_o,
  output logic [1:0]        occ_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                s_ready_q;
  logic                m_valid_q;
  logic [PC_W-1:0]     main_pc_q;
  logic [INST_W-1:0]   main_inst_q;
  logic [PC_W-1:0]     skid_pc_q;
  logic [INST_W-1:0]   skid_inst_q;

  logic                up_xfer;
  logic                dn_xfer;
  logic                load_main_in;
  logic                load_main_skid;
  logic                load_skid;
  logic                load_nop;

  // Handshakes use only registered ready/valid, so no m_ready_i -> s_ready_o path exists.
  assign up_xfer = s_valid_i & s_ready_q;
  assign dn_xfer = m_valid_q & m_ready_i;

  // State register; ready/valid flags are precomputed from the next state so they are pure flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d != ST_TWO);
      m_valid_q <= (state_d != ST_EMPTY);
    end
  end

  // Next-state logic; flush overrides every handshake.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = BUBBLE_VALID ? ST_ONE : ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (up_xfer) state_d = ST_ONE;
        ST_ONE: begin
          if (dn_xfer && !up_xfer)      state_d = ST_EMPTY;
          else if (up_xfer && !dn_xfer) state_d = ST_TWO;
        end
        ST_TWO:   if (m_ready_i) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Output/datapath control decode: which register loads from where this cycle.
  always_comb begin
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    load_nop       = 1'b0;
    if (flush_i) begin
      load_nop = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: load_main_in = up_xfer;
        ST_ONE: begin
          if (up_xfer && dn_xfer) load_main_in = 1'b1;
          else if (up_xfer)       load_skid    = 1'b1;
        end
        ST_TWO:   load_main_skid = m_ready_i;
        default: ;
      endcase
    end
  end

  // Main payload register; holds its value whenever nothing loads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_pc_q   <= '0;
      main_inst_q <= '0;
    end else if (load_nop) begin
      main_pc_q   <= '0;
      main_inst_q <= NOP_INST;
    end else if (load_main_skid) begin
      main_pc_q   <= skid_pc_q;
      main_inst_q <= skid_inst_q;
    end else if (load_main_in) begin
      main_pc_q   <= s_pc_i;
      main_inst_q <= s_inst_i;
    end
  end

  // Skid payload register; contents after a flush are never observed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
    end else if (load_skid) begin
      skid_pc_q   <= s_pc_i;
      skid_inst_q <= s_inst_i;
    end
  end

  assign s_ready_o = s_ready_q;
  assign m_valid_o = m_valid_q;
  assign m_pc_o    = main_pc_q;
  assign m_inst_o  = main_inst_q;
  assign occ_o     = state_q;

endmodule

// File: tb/tb_if_de_skid.sv
// Bench for if_de_skid: two instances (BUBBLE_VALID = 0 and 1) share stimulus,
// each compared every cycle against a queue-based model of the stage.
module tb_if_de_skid;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_pc = '0;
  logic [31:0] s_inst = '0;
  logic        m_ready = 1'b0;

  logic        s_ready0, m_valid0, s_ready1, m_valid1;
  logic [31:0] m_pc0, m_inst0, m_pc1, m_inst1;
  logic [1:0]  occ0, occ1;

  int checks = 0;
  int failures = 0;

  ent_t q0[$];
  ent_t q1[$];

  always #5 clk = ~clk;

  if_de_skid #(.PC_W(32), .INST_W(32), .NOP_INST(NOP), .BUBBLE_VALID(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .s_valid_i(s_valid), .s_ready_o(s_ready0), .s_pc_i(s_pc), .s_inst_i(s_inst),
    .m_valid_o(m_valid0), .m_ready_i(m_ready), .m_pc_o(m_pc0), .m_inst_o(m_inst0),
    .occ_o(occ0)
  );

  if_de_skid #(.PC_W(32), .INST_W(32), .NOP_INST(NOP), .BUBBLE_VALID(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .s_valid_i(s_valid), .s_ready_o(s_ready1), .s_pc_i(s_pc), .s_inst_i(s_inst),
    .m_valid_o(m_valid1), .m_ready_i(m_ready), .m_pc_o(m_pc1), .m_inst_o(m_inst1),
    .occ_o(occ1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_dut(input string nm, input logic [1:0] occ, input logic mv, input logic sr,
                           input logic [31:0] pc, input logic [31:0] inst,
                           input int sz, input ent_t head);
    check({nm, ".occ"}, 64'(occ), 64'(sz));
    check({nm, ".m_valid"}, 64'(mv), 64'(sz > 0));
    check({nm, ".s_ready"}, 64'(sr), 64'(sz < 2));
    if (sz > 0) begin
      check({nm, ".m_pc"}, 64'(pc), 64'(head.pc));
      check({nm, ".m_inst"}, 64'(inst), 64'(head.inst));
    end
  endtask

  task automatic check_outputs();
    ent_t h0, h1;
    h0 = '0;
    h1 = '0;
    if (q0.size() > 0) h0 = q0[0];
    if (q1.size() > 0) h1 = q1[0];
    check_dut("bv0", occ0, m_valid0, s_ready0, m_pc0, m_inst0, q0.size(), h0);
    check_dut("bv1", occ1, m_valid1, s_ready1, m_pc1, m_inst1, q1.size(), h1);
  endtask

  // Stage as an ordered queue of at most two entries.
  task automatic model_update();
    bit up, dn;
    if (flush) begin
      q0.delete();
      q1.delete();
      q1.push_back('{pc: 32'h0, inst: NOP});
    end else begin
      up = s_valid && (q0.size() < 2);
      dn = m_ready && (q0.size() > 0);
      if (dn) void'(q0.pop_front());
      if (up) q0.push_back('{pc: s_pc, inst: s_inst});
      up = s_valid && (q1.size() < 2);
      dn = m_ready && (q1.size() > 0);
      if (dn) void'(q1.pop_front());
      if (up) q1.push_back('{pc: s_pc, inst: s_inst});
    end
  endtask

  // Check the state produced by the previous cycle, then drive this cycle's inputs.
  task automatic step(input bit fl, input bit sv, input logic [31:0] inst, input bit mr);
    @(negedge clk);
    check_outputs();
    flush   = fl;
    s_valid = sv;
    s_inst  = inst;
    s_pc    = 32'h1000 + (inst << 2);
    m_ready = mr;
    model_update();
  endtask

  task automatic check_reset_values();
    check("rst.occ0", 64'(occ0), 64'd0);
    check("rst.m_valid0", 64'(m_valid0), 64'd0);
    check("rst.s_ready0", 64'(s_ready0), 64'd1);
    check("rst.m_pc0", 64'(m_pc0), 64'd0);
    check("rst.m_inst0", 64'(m_inst0), 64'd0);
    check("rst.occ1", 64'(occ1), 64'd0);
    check("rst.m_valid1", 64'(m_valid1), 64'd0);
    check("rst.s_ready1", 64'(s_ready1), 64'd1);
    check("rst.m_pc1", 64'(m_pc1), 64'd0);
    check("rst.m_inst1", 64'(m_inst1), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;

    // Streaming 0x11..0x14 with decode always ready
    for (int i = 0; i < 4; i++) step(0, 1, 32'h11 + 32'(i), 1);
    step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 1);

    // Skid fill: decode stalls, 0x23 held by fetch, then released
    step(0, 1, 32'h21, 0);
    step(0, 1, 32'h22, 0);
    step(0, 1, 32'h23, 0);
    step(0, 1, 32'h23, 0);
    step(0, 1, 32'h23, 1);
    step(0, 1, 32'h23, 1);
    step(0, 0, 32'h0, 1);

    // Simultaneous in/out while ONE
    step(0, 1, 32'h41, 0);
    step(0, 1, 32'h42, 1);
    step(0, 0, 32'h0, 0);

    // Flush in TWO with input presented, then NOP held two cycles
    step(0, 1, 32'h31, 0);
    step(0, 1, 32'h32, 0);
    step(1, 1, 32'h33, 0);
    step(0, 0, 32'h0, 0);
    step(0, 0, 32'h0, 0);
    step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 0);

    // Three-cycle flush
    step(0, 1, 32'h51, 0);
    step(1, 1, 32'h52, 0);
    step(1, 1, 32'h53, 1);
    step(1, 1, 32'h54, 0);
    step(0, 0, 32'h0, 0);
    step(0, 0, 32'h0, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 70,
           $urandom, $urandom_range(0, 99) < 60);

    // Async reset mid-stream with two entries held
    step(0, 1, 32'h61, 0);
    step(0, 1, 32'h62, 0);
    step(0, 0, 32'h0, 0);
    @(negedge clk);
    check_outputs();
    #2 rst_n = 1'b0;
    #1 check_reset_values();
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 32'h71, 1);
    step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
